// File: rtl/adc_sample_packer.sv
// Packs framed MCP3008 conversion words into an 8-deep FIFO and streams each entry
// as a {marker/channel/sample-high, sample-low} byte pair, with overflow and framing-error status.
module adc_sample_packer #(
  parameter int DEPTH = 8,
  parameter int ERR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [15:0]              in_word,
  input  logic                     in_avail,
  output logic                     in_accept,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     clear,
  output logic                     overflow,
  output logic [ERR_W-1:0]         err_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {I_IDLE = 1'b0, I_ACK = 1'b1} in_state_t;
  typedef enum logic [1:0] {O_IDLE = 2'd0, O_HI = 2'd1, O_LO = 2'd2} out_state_t;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] hi_byte(input logic [12:0] e);
    return {1'b1, e[12:10], 2'b00, e[9:8]};
  endfunction

  logic            avail_p0, avail_s;
  in_state_t       in_state, in_state_nxt;
  out_state_t      out_state, out_state_nxt;
  logic            capture, word_ok, push, pop, drop_full, bad_word;
  logic [12:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic [7:0]      hold_lo_p1;

  // Stage p0/p1: two-flop synchroniser on the upstream avail level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avail_p0 <= 1'b0;
      avail_s  <= 1'b0;
    end else begin
      avail_p0 <= in_avail;
      avail_s  <= avail_p0;
    end
  end

  always_comb begin
    capture      = 1'b0;
    in_state_nxt = in_state;
    case (in_state)
      I_IDLE: if (avail_s) begin
        capture      = 1'b1;
        in_state_nxt = I_ACK;
      end
      I_ACK:  if (!avail_s) in_state_nxt = I_IDLE;
      default: in_state_nxt = I_IDLE;
    endcase
  end

  always_comb begin
    pop           = 1'b0;
    out_state_nxt = out_state;
    case (out_state)
      O_IDLE: if (level != '0) begin
        pop           = 1'b1;
        out_state_nxt = O_HI;
      end
      O_HI:   if (out_ready) out_state_nxt = O_LO;
      O_LO:   if (out_ready) begin
        if (level != '0) begin
          pop           = 1'b1;
          out_state_nxt = O_HI;
        end else begin
          out_state_nxt = O_IDLE;
        end
      end
      default: out_state_nxt = O_IDLE;
    endcase
  end

  // A full FIFO still takes a word when the same edge frees a slot
  assign word_ok   = in_word[15] & in_word[14] & in_word[10];
  assign push      = capture && word_ok && ((level < LW'(DEPTH)) || pop);
  assign drop_full = capture && word_ok && !push;
  assign bad_word  = capture && !word_ok;

  assign in_accept  = (in_state == I_ACK);
  assign out_valid  = (out_state != O_IDLE);
  assign fifo_level = level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state  <= I_IDLE;
      out_state <= O_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_data  <= 8'h00;
      overflow  <= 1'b0;
      err_count <= '0;
    end else begin
      in_state  <= in_state_nxt;
      out_state <= out_state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (pop)
        out_data <= hi_byte(mem[rd_ptr]);
      else if (out_state == O_HI && out_ready)
        out_data <= hold_lo_p1;
      if (clear)          overflow <= 1'b0;
      else if (drop_full) overflow <= 1'b1;
      if (clear)          err_count <= '0;
      else if (bad_word)  err_count <= sat_inc(err_count);
    end
  end

  // Stage p1: FIFO storage and low-byte holding register (data only, no reset)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_word[13:11], in_word[9:0]};
    if (pop)  hold_lo_p1  <= mem[rd_ptr][7:0];
  end

endmodule

// File: tb/tb_adc_sample_packer.sv
// Randomised and directed bench for adc_sample_packer against a queue-based byte-stream model.
module tb_adc_sample_packer;

  localparam int DEPTH   = 8;
  localparam int ERR_W   = 8;
  localparam int ERR_MAX = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_word;
  logic        in_avail;
  logic        in_accept;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        clear;
  logic        overflow;
  logic [7:0]  err_count;
  logic [3:0]  fifo_level;

  adc_sample_packer #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_avail(in_avail),
    .in_accept(in_accept), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .clear(clear), .overflow(overflow),
    .err_count(err_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q [$];
  logic [7:0] seen_q [$];
  int         exp_err = 0;
  logic       exp_ovf = 1'b0;
  logic       mon_en  = 1'b0;
  logic       stalled = 1'b0;
  logic [7:0] stalled_data = 8'h00;
  logic       done_flag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_to(input string name);
    n_checks++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a word is kept if fewer than DEPTH+1 words (FIFO plus holding) are still unsent
  task automatic model_capture(input logic [15:0] w);
    int outstanding;
    if (w[15] && w[14] && w[10]) begin
      outstanding = (exp_q.size() + 1) / 2;
      if (outstanding < DEPTH + 1) begin
        exp_q.push_back(8'h80 | 8'(w[13:11] << 4) | 8'(w[9:8]));
        exp_q.push_back(w[7:0]);
      end else begin
        exp_ovf = 1'b1;
      end
    end else begin
      exp_err = (exp_err >= ERR_MAX) ? ERR_MAX : exp_err + 1;
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    bit got;
    in_word  = w;
    in_avail = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (in_accept) got = 1;
    end
    if (!got) fail_to("accept_rise");
    else model_capture(w);
    in_avail = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (!in_accept) got = 1;
    end
    if (!got) fail_to("accept_fall");
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) fail_to("drain");
    step(); step(); step();
    chk("drain_level", 32'(fifo_level), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_err = 0;
    exp_ovf = 1'b0;
  endtask

  // Compare process: byte stream, stall stability and status every cycle
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(stalled_data));
      end
      if (out_valid && out_ready) begin
        seen_q.push_back(out_data);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_byte: got %02h expected no byte", out_data);
        end else begin
          chk("byte", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      stalled      = out_valid && !out_ready;
      stalled_data = out_data;
      chk("err_count", 32'(err_count), 32'(exp_err));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
    end
  end

  initial begin
    logic [15:0] w;
    int zeros;
    rst_n = 1'b0; in_word = 16'h0; in_avail = 1'b0; out_ready = 1'b0; clear = 1'b0;
    step(); step(); step();
    chk("rst_accept", 32'(in_accept), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;

    // Single word, latency and handshake timing
    out_ready = 1'b1;
    in_word = 16'hDEA5; in_avail = 1'b1;
    step(); chk("acc_E", 32'(in_accept), 32'd0);
    step(); chk("acc_E1", 32'(in_accept), 32'd0);
    step(); chk("acc_E2", 32'(in_accept), 32'd1);
    model_capture(16'hDEA5);
    step(); chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_hi", 32'(out_data), 32'h0B2);
    in_avail = 1'b0;
    step(); chk("acc_F", 32'(in_accept), 32'd1);
    chk("first_lo", 32'(out_data), 32'h0A5);
    step(); chk("acc_F1", 32'(in_accept), 32'd1);
    step(); chk("acc_F2", 32'(in_accept), 32'd0);
    step(); step();
    chk("t1_level", 32'(fifo_level), 32'd0);
    chk("t1_valid", 32'(out_valid), 32'd0);

    // Framing error
    send_word(16'h8400);
    step(); step();
    chk("bad_err", 32'(err_count), 32'd1);
    chk("bad_level", 32'(fifo_level), 32'd0);

    // Back-pressure fill and overflow
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) send_word(16'hC400 | 16'(i << 11) | 16'(10'h155 + 10'(i * 37)));
    chk("full_level", 32'(fifo_level), 32'd8);
    chk("full_ovf", 32'(overflow), 32'd0);
    send_word(16'hFFFF);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(fifo_level), 32'd8);
    pulse_clear();
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_err", 32'(err_count), 32'd0);

    // Full FIFO, pair completion coincides with push
    out_ready = 1'b1; step(); out_ready = 1'b0;
    in_word = 16'hCD23; in_avail = 1'b1;
    step(); step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("coin_accept", 32'(in_accept), 32'd1);
    model_capture(16'hCD23);
    chk("coin_level", 32'(fifo_level), 32'd8);
    chk("coin_ovf", 32'(overflow), 32'd0);
    in_avail = 1'b0;
    step(); step(); step();
    drain();

    // out_ready toggling every cycle, 3-word burst
    done_flag = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        send_word(16'hC6F0); send_word(16'hF7FF); send_word(16'hD480);
        done_flag = 1'b1;
      end
      begin
        while (!done_flag) begin step(); out_ready = ~out_ready; end
      end
    join
    drain();

    // Randomised words with bounded back-pressure
    done_flag = 1'b0;
    zeros = 0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          w = 16'($urandom);
          if ($urandom_range(3) != 0) begin w[15] = 1'b1; w[14] = 1'b1; w[10] = 1'b1; end
          send_word(w);
          repeat ($urandom_range(3)) step();
        end
        done_flag = 1'b1;
      end
      begin
        while (!done_flag) begin
          step();
          if (zeros >= 2) out_ready = 1'b1;
          else out_ready = 1'($urandom_range(1));
          zeros = out_ready ? 0 : zeros + 1;
        end
      end
    join
    drain();
    chk("rnd_ovf", 32'(overflow), 32'd0);

    // Reset mid-pair
    out_ready = 1'b0;
    send_word(16'hC512); send_word(16'hC634); send_word(16'hC756);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    exp_err = 0;
    exp_ovf = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_data", 32'(out_data), 32'd0);
    chk("mrst_accept", 32'(in_accept), 32'd0);
    chk("mrst_level", 32'(fifo_level), 32'd0);
    chk("mrst_ovf", 32'(overflow), 32'd0);
    chk("mrst_err", 32'(err_count), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    seen_q.delete();
    out_ready = 1'b1;
    send_word(16'hEFFF);
    drain();
    chk("post_rst_count", 32'(seen_q.size()), 32'd2);
    if (seen_q.size() >= 2) begin
      chk("post_rst_hi", 32'(seen_q[0]), 32'h0D3);
      chk("post_rst_lo", 32'(seen_q[1]), 32'h0FF);
    end

    // Error counter saturation and clear
    for (int n = 0; n < 300; n++) begin
      w = 16'($urandom);
      case (n % 3)
        0: w[15] = 1'b0;
        1: w[14] = 1'b0;
        default: w[10] = 1'b0;
      endcase
      send_word(w);
    end
    chk("err_sat", 32'(err_count), 32'd255);
    pulse_clear();
    chk("err_clr", 32'(err_count), 32'd0);
    step();

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
